multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
Moore-style control FSM that sequences a multicycle build of the MIPS-subset datapath. That build uses a single shared memory port, an instruction register (IR), an ALUOut register, and the same regfile, ALU and mux set as the single-cycle core. The controller fetches, decodes and executes LW, SW, J, JAL, JR, BNE, XORI, ADDI, ADD, SUB and SLT. It uses a req/ready handshake to memory, with a timeout watchdog. Decode inputs come from the IR, which is held stable between fetches.

Parameters:
WAIT_MAX, 15, maximum cycles memReq may stay unacknowledged before a bus-error trap.
WAIT_W, 4, width of the wait counter; must satisfy 2^WAIT_W > WAIT_MAX.

Ports:
clk  in  1  system clock, rising edge
rstN  in  1  asynchronous active-low reset
opcode  in  6  IR[31:26]
funct  in  6  IR[5:0]
aluZero  in  1  ALU zero flag
memReady  in  1  memory acknowledge; sampled only while memReq=1
memReq  out  1  memory access request
memWe  out  1  memory write enable (data access only)
iOrD  out  1  memory address select: 0=PC, 1=ALUOut
irWe  out  1  IR load
pcWe  out  1  PC load
pcSrc  out  2  PC source: 0=ALU result, 1=jump addr {PC[31:28],IR[25:0],2'b0}, 2=regA, 3=ALUOut
aluASrc  out  1  ALU operand A: 0=PC, 1=regA
aluBSrc  out  2  ALU operand B: 0=regB, 1=constant 4, 2=extended imm, 3=imm<<2
aluCmd  out  3  ALU command: 0=ADD, 1=SUB, 2=XOR, 3=SLT
regWe  out  1  regfile write enable
regWAddrSel  out  2  write address select: 0=rd, 1=rt, 2=r31
regDInCtrl  out  2  write data select: 0=ALUOut, 1=memory data, 2=PC
state  out  4  current state, for debug
trap  out  1  sticky illegal-instruction or bus-error flag
busErr  out  1  sticky; set only for a timeout trap

Behaviour:
- Reset (rstN low, async): state=FETCH (0), wait counter=0, trap=0, busErr=0. Every output is forced to 0 while rstN is low, including memReq. The first fetch begins on the first posedge after rstN deasserts.
- State encoding: FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, MEM_ADDR=4, MEM_RD=5, MEM_WR=6, WB_ALU=7, WB_MEM=8, BRANCH=9, JUMP=10, TRAP=11. Codes 12-15 go to TRAP on the next edge.
- Any output not listed for a state is 0.
- FETCH:
  - Drives memReq=1, iOrD=0, aluASrc=0, aluBSrc=1, aluCmd=ADD.
  - irWe and pcWe equal memReady, with pcSrc=0, so PC+4 is committed in the same edge that loads the IR.
  - On memReady, go to DECODE; otherwise stay.
- DECODE: aluASrc=0, aluBSrc=3, aluCmd=ADD; the branch target is latched into ALUOut. Next state by opcode:
  - opcode 0x00 with funct 0x20/0x22/0x2A goes to EXEC_R.
  - opcode 0x00 with funct 0x08 goes to JUMP.
  - 0x02/0x03 go to JUMP.
  - 0x08/0x0E go to EXEC_I.
  - 0x23/0x2B go to MEM_ADDR.
  - 0x05 goes to BRANCH.
  - Anything else goes to TRAP.
- EXEC_R: aluASrc=1, aluBSrc=0, aluCmd from funct (0x20=ADD, 0x22=SUB, 0x2A=SLT). Next: WB_ALU.
- EXEC_I: aluASrc=1, aluBSrc=2, aluCmd=ADD for 0x08, XOR for 0x0E. Next: WB_ALU.
- WB_ALU: regWe=1, regDInCtrl=0, regWAddrSel=0 for R-type, 1 for I-type. Next: FETCH.
- MEM_ADDR: aluASrc=1, aluBSrc=2, ADD. Next: MEM_RD for 0x23, MEM_WR for 0x2B.
- MEM_RD: memReq=1, iOrD=1. On memReady go to WB_MEM; otherwise stay.
- WB_MEM: regWe=1, regDInCtrl=1, regWAddrSel=1. Next: FETCH.
- MEM_WR: memReq=1, memWe=1, iOrD=1. The write commits on the edge where memReady=1, then go to FETCH.
- BRANCH: aluASrc=1, aluBSrc=0, SUB. pcWe=~aluZero with pcSrc=3. Next: FETCH.
- JUMP: pcWe=1. pcSrc=2 for JR, 1 for J/JAL. JAL additionally drives regWe=1, regWAddrSel=2, regDInCtrl=2; PC already holds PC+4. Next: FETCH.
- Handshake:
  - The address and memWe are held stable from the first memReq cycle until memReady.
  - Ready in the same cycle as the request gives a single-cycle access.
  - memReady while memReq=0 is ignored.
- Wait counter:
  - Clears on every state change.
  - Increments each cycle spent in FETCH, MEM_RD or MEM_WR with memReady=0.
  - If it equals WAIT_MAX while memReady=0, the next state is TRAP and busErr is set.
  - If memReady arrives in that same cycle, the access completes normally.
- TRAP:
  - Absorbing state; only reset exits it.
  - trap=1, all enables 0.
  - busErr stays 0 for an illegal opcode.
- Reset mid-access: memReq drops immediately (async). No partial write is claimed.
- Cycle counts with zero-wait memory: R-type/ADDI/XORI 4; LW 5; SW 4; BNE 3; J/JR/JAL 3.

Test Plan:
- Reset, then ADD (opcode 0, funct 0x20) with memReady=1 -> states 0,1,2,7,0; irWe=pcWe=1 in the FETCH cycle; regWe=1 with regWAddrSel=0 in WB_ALU; aluCmd=0 in EXEC_R.
- LW 0x23 with memReady delayed 3 cycles in MEM_RD -> memReq/iOrD=1 held 4 cycles; WB_MEM has regDInCtrl=1 and regWAddrSel=1; 8 cycles total.
- BNE 0x05: aluZero=0 -> pcWe=1 with pcSrc=3 in BRANCH; aluZero=1 -> pcWe=0; both return to FETCH.
- JAL 0x03 -> JUMP drives pcSrc=1, regWe=1, regWAddrSel=2, regDInCtrl=2. JR (0/0x08) -> pcSrc=2, regWe=0.
- Opcode 0x3F -> TRAP, trap=1, busErr=0, stays there 20 cycles. Assert rstN=0 mid-TRAP -> state=0 and trap=0 at once, with no clock edge.
- memReady held 0 in FETCH with WAIT_MAX=15 -> TRAP on the 16th edge, busErr=1. Repeat with memReady=1 in the 16th cycle -> DECODE, no trap.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_if
// Shared-memory port of the multicycle MIPS-subset datapath.
//   memReq   : access request, raised by the controller
//   memWe    : write enable for a data access
//   iOrD     : address select, 0 = PC (instruction), 1 = ALUOut (data)
//   memReady : acknowledge from memory, only meaningful while memReq = 1
// The controller uses the master modport; the memory uses the slave modport.
// ---------------------------------------------------------------------------
interface multicycle_ctrl_if;
  logic memReq;
  logic memWe;
  logic iOrD;
  logic memReady;

  modport master (
    output memReq,
    output memWe,
    output iOrD,
    input  memReady
  );

  modport slave (
    input  memReq,
    input  memWe,
    input  iOrD,
    output memReady
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
// Moore control FSM for the multicycle MIPS-subset datapath (shared memory
// port, IR, ALUOut). Sequences LW, SW, J, JAL, JR, BNE, XORI, ADDI, ADD,
// SUB and SLT, with a watchdog on the memory handshake.
//
// Ports:
//   clk, rstN          clock (rising edge), asynchronous active-low reset
//   bus                memory handshake (memReq/memWe/iOrD out, memReady in)
//   opcode, funct      IR[31:26] and IR[5:0], stable between fetches
//   aluZero            ALU zero flag, used by BNE
//   irWe, pcWe, pcSrc  IR load, PC load and PC source select
//   aluASrc, aluBSrc   ALU operand selects
//   aluCmd             0=ADD 1=SUB 2=XOR 3=SLT
//   regWe, regWAddrSel, regDInCtrl  register-file write controls
//   state              current state code, for debug
//   trap, busErr       sticky trap flag and timeout-cause flag
// ---------------------------------------------------------------------------
module multicycle_ctrl #(
  parameter int WAIT_MAX = 15,
  parameter int WAIT_W   = 4
) (
  input  logic              clk,
  input  logic              rstN,
  multicycle_ctrl_if.master bus,
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  input  logic              aluZero,
  output logic              irWe,
  output logic              pcWe,
  output logic [1:0]        pcSrc,
  output logic              aluASrc,
  output logic [1:0]        aluBSrc,
  output logic [2:0]        aluCmd,
  output logic              regWe,
  output logic [1:0]        regWAddrSel,
  output logic [1:0]        regDInCtrl,
  output logic [3:0]        state,
  output logic              trap,
  output logic              busErr
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    EXEC_I   = 4'd3,
    MEM_ADDR = 4'd4,
    MEM_RD   = 4'd5,
    MEM_WR   = 4'd6,
    WB_ALU   = 4'd7,
    WB_MEM   = 4'd8,
    BRANCH   = 4'd9,
    JUMP     = 4'd10,
    TRAP     = 4'd11
  } stateT;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_XOR = 3'd2;
  localparam logic [2:0] ALU_SLT = 3'd3;

  // Registered control word. The *Arm bits mark states whose PC/IR enables
  // are qualified by a live input (memReady or aluZero) in the same cycle.
  typedef struct packed {
    logic       memReq;
    logic       memWe;
    logic       iOrD;
    logic       fetchArm;
    logic       branchArm;
    logic       jumpArm;
    logic [1:0] pcSrc;
    logic       aluASrc;
    logic [1:0] aluBSrc;
    logic [2:0] aluCmd;
    logic       regWe;
    logic [1:0] regWAddrSel;
    logic [1:0] regDInCtrl;
    logic       trap;
  } ctrlT;

  stateT             curState;
  stateT             nextState;
  stateT             decodeTarget;
  ctrlT              ctrlQ;
  ctrlT              ctrlD;
  logic [WAIT_W-1:0] waitCnt;
  logic              busErrQ;
  logic              stalled;
  logic              accessDone;
  logic              timeout;

  // Handshake status is judged against the registered memReq, so memReady
  // arriving when no request is outstanding (including the cycle right
  // after reset release) has no effect.
  assign stalled    = ctrlQ.memReq & ~bus.memReady;
  assign accessDone = ctrlQ.memReq & bus.memReady;
  assign timeout    = stalled && (waitCnt == WAIT_W'(WAIT_MAX));

  // Instruction decode: picks the execution path out of DECODE. Anything
  // outside the supported subset lands in TRAP.
  always_comb begin
    decodeTarget = TRAP;
    case (opcode)
      OP_RTYPE: begin
        if (funct == FN_ADD || funct == FN_SUB || funct == FN_SLT) begin
          decodeTarget = EXEC_R;
        end else if (funct == FN_JR) begin
          decodeTarget = JUMP;
        end
      end
      OP_J, OP_JAL:     decodeTarget = JUMP;
      OP_ADDI, OP_XORI: decodeTarget = EXEC_I;
      OP_LW, OP_SW:     decodeTarget = MEM_ADDR;
      OP_BNE:           decodeTarget = BRANCH;
      default:          decodeTarget = TRAP;
    endcase
  end

  // Next-state logic. The memory states wait for an acknowledge and fall
  // into TRAP once the watchdog expires; an acknowledge in the expiry cycle
  // still wins. Unused codes also fall into TRAP.
  always_comb begin
    nextState = curState;
    case (curState)
      FETCH:    nextState = accessDone ? DECODE : (timeout ? TRAP : FETCH);
      DECODE:   nextState = decodeTarget;
      EXEC_R:   nextState = WB_ALU;
      EXEC_I:   nextState = WB_ALU;
      MEM_ADDR: nextState = (opcode == OP_LW) ? MEM_RD : MEM_WR;
      MEM_RD:   nextState = accessDone ? WB_MEM : (timeout ? TRAP : MEM_RD);
      MEM_WR:   nextState = accessDone ? FETCH : (timeout ? TRAP : MEM_WR);
      WB_ALU:   nextState = FETCH;
      WB_MEM:   nextState = FETCH;
      BRANCH:   nextState = FETCH;
      JUMP:     nextState = FETCH;
      TRAP:     nextState = TRAP;
      default:  nextState = TRAP;
    endcase
  end

  // Control word for the state being entered. It is registered together
  // with the state, so every output is glitch-free and settles right at the
  // start of its state. Decode fields only depend on the IR, which is
  // already loaded by the time any of them matters.
  always_comb begin
    ctrlD = '0;
    case (nextState)
      FETCH: begin
        ctrlD.memReq   = 1'b1;
        ctrlD.fetchArm = 1'b1;
        ctrlD.aluBSrc  = 2'd1;
        ctrlD.aluCmd   = ALU_ADD;
      end
      DECODE: begin
        ctrlD.aluBSrc = 2'd3;
        ctrlD.aluCmd  = ALU_ADD;
      end
      EXEC_R: begin
        ctrlD.aluASrc = 1'b1;
        ctrlD.aluCmd  = (funct == FN_SUB) ? ALU_SUB :
                        (funct == FN_SLT) ? ALU_SLT : ALU_ADD;
      end
      EXEC_I: begin
        ctrlD.aluASrc = 1'b1;
        ctrlD.aluBSrc = 2'd2;
        ctrlD.aluCmd  = (opcode == OP_XORI) ? ALU_XOR : ALU_ADD;
      end
      MEM_ADDR: begin
        ctrlD.aluASrc = 1'b1;
        ctrlD.aluBSrc = 2'd2;
        ctrlD.aluCmd  = ALU_ADD;
      end
      MEM_RD: begin
        ctrlD.memReq = 1'b1;
        ctrlD.iOrD   = 1'b1;
      end
      MEM_WR: begin
        ctrlD.memReq = 1'b1;
        ctrlD.memWe  = 1'b1;
        ctrlD.iOrD   = 1'b1;
      end
      WB_ALU: begin
        ctrlD.regWe       = 1'b1;
        ctrlD.regWAddrSel = (opcode == OP_RTYPE) ? 2'd0 : 2'd1;
      end
      WB_MEM: begin
        ctrlD.regWe       = 1'b1;
        ctrlD.regWAddrSel = 2'd1;
        ctrlD.regDInCtrl  = 2'd1;
      end
      BRANCH: begin
        ctrlD.aluASrc   = 1'b1;
        ctrlD.aluCmd    = ALU_SUB;
        ctrlD.pcSrc     = 2'd3;
        ctrlD.branchArm = 1'b1;
      end
      JUMP: begin
        ctrlD.jumpArm = 1'b1;
        ctrlD.pcSrc   = (opcode == OP_RTYPE) ? 2'd2 : 2'd1;
        if (opcode == OP_JAL) begin
          ctrlD.regWe       = 1'b1;
          ctrlD.regWAddrSel = 2'd2;
          ctrlD.regDInCtrl  = 2'd2;
        end
      end
      TRAP: begin
        ctrlD.trap = 1'b1;
      end
      default: ctrlD = '0;
    endcase
  end

  // State, control word, watchdog and bus-error flag. Reset clears the
  // control word too, so memReq drops the moment rstN falls. The watchdog
  // restarts on every state change and only counts unacknowledged cycles.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      curState <= FETCH;
      ctrlQ    <= '0;
      waitCnt  <= '0;
      busErrQ  <= 1'b0;
    end else begin
      curState <= nextState;
      ctrlQ    <= ctrlD;
      if (nextState != curState) begin
        waitCnt <= '0;
      end else if (stalled) begin
        waitCnt <= waitCnt + 1'b1;
      end
      if (timeout) begin
        busErrQ <= 1'b1;
      end
    end
  end

  // The IR and PC+4 commit on the same edge as the fetch acknowledge; BNE
  // only redirects the PC when the compared registers differ.
  assign irWe = ctrlQ.fetchArm & bus.memReady;
  assign pcWe = (ctrlQ.fetchArm & bus.memReady) |
                (ctrlQ.branchArm & ~aluZero) |
                ctrlQ.jumpArm;

  assign bus.memReq  = ctrlQ.memReq;
  assign bus.memWe   = ctrlQ.memWe;
  assign bus.iOrD    = ctrlQ.iOrD;
  assign pcSrc       = ctrlQ.pcSrc;
  assign aluASrc     = ctrlQ.aluASrc;
  assign aluBSrc     = ctrlQ.aluBSrc;
  assign aluCmd      = ctrlQ.aluCmd;
  assign regWe       = ctrlQ.regWe;
  assign regWAddrSel = ctrlQ.regWAddrSel;
  assign regDInCtrl  = ctrlQ.regDInCtrl;
  assign state       = curState;
  assign trap        = ctrlQ.trap;
  assign busErr      = busErrQ;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
// Self-checking bench for multicycle_ctrl. Each scenario queues per-cycle
// stimulus together with the expected state and control outputs, then
// replays the queue and compares the DUT cycle by cycle.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_EXECR  = 4'd2;
  localparam logic [3:0] S_EXECI  = 4'd3;
  localparam logic [3:0] S_MADDR  = 4'd4;
  localparam logic [3:0] S_MRD    = 4'd5;
  localparam logic [3:0] S_MWR    = 4'd6;
  localparam logic [3:0] S_WBALU  = 4'd7;
  localparam logic [3:0] S_WBMEM  = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;
  localparam logic [3:0] S_JUMP   = 4'd10;
  localparam logic [3:0] S_TRAP   = 4'd11;

  logic        clk = 1'b0;
  logic        rstN;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        aluZero;
  logic        irWe;
  logic        pcWe;
  logic [1:0]  pcSrc;
  logic        aluASrc;
  logic [1:0]  aluBSrc;
  logic [2:0]  aluCmd;
  logic        regWe;
  logic [1:0]  regWAddrSel;
  logic [1:0]  regDInCtrl;
  logic [3:0]  dbgState;
  logic        trap;
  logic        busErr;
  logic [19:0] obsCtl;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  st;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        rdy;
    logic        zero;
    logic [19:0] ctl;
    string       tag;
  } sbEntry;

  sbEntry sbQ[$];

  multicycle_ctrl_if bus();

  multicycle_ctrl #(.WAIT_MAX(15), .WAIT_W(4)) dut (
    .clk         (clk),
    .rstN        (rstN),
    .bus         (bus),
    .opcode      (opcode),
    .funct       (funct),
    .aluZero     (aluZero),
    .irWe        (irWe),
    .pcWe        (pcWe),
    .pcSrc       (pcSrc),
    .aluASrc     (aluASrc),
    .aluBSrc     (aluBSrc),
    .aluCmd      (aluCmd),
    .regWe       (regWe),
    .regWAddrSel (regWAddrSel),
    .regDInCtrl  (regDInCtrl),
    .state       (dbgState),
    .trap        (trap),
    .busErr      (busErr)
  );

  always #5 clk = ~clk;

  assign obsCtl = {bus.memReq, bus.memWe, bus.iOrD, irWe, pcWe, pcSrc, aluASrc,
                   aluBSrc, aluCmd, regWe, regWAddrSel, regDInCtrl, trap, busErr};

  // Expected outputs for one cycle, straight from the per-state output table.
  function automatic logic [19:0] specCtl(logic [3:0] st, logic [5:0] op, logic [5:0] fn,
                                          logic rdy, logic zero, logic be);
    logic       mReq = 1'b0;
    logic       mWe  = 1'b0;
    logic       ioD  = 1'b0;
    logic       ir   = 1'b0;
    logic       pw   = 1'b0;
    logic       aA   = 1'b0;
    logic       rw   = 1'b0;
    logic       tr   = 1'b0;
    logic       eb   = 1'b0;
    logic [1:0] ps   = 2'd0;
    logic [1:0] aB   = 2'd0;
    logic [1:0] wa   = 2'd0;
    logic [1:0] di   = 2'd0;
    logic [2:0] cmd  = 3'd0;
    case (st)
      S_FETCH:  begin mReq = 1'b1; aB = 2'd1; ir = rdy; pw = rdy; end
      S_DECODE: aB = 2'd3;
      S_EXECR:  begin aA = 1'b1; cmd = (fn == 6'h22) ? 3'd1 : (fn == 6'h2A) ? 3'd3 : 3'd0; end
      S_EXECI:  begin aA = 1'b1; aB = 2'd2; cmd = (op == 6'h0E) ? 3'd2 : 3'd0; end
      S_MADDR:  begin aA = 1'b1; aB = 2'd2; end
      S_MRD:    begin mReq = 1'b1; ioD = 1'b1; end
      S_MWR:    begin mReq = 1'b1; mWe = 1'b1; ioD = 1'b1; end
      S_WBALU:  begin rw = 1'b1; wa = (op == 6'h00) ? 2'd0 : 2'd1; end
      S_WBMEM:  begin rw = 1'b1; di = 2'd1; wa = 2'd1; end
      S_BRANCH: begin aA = 1'b1; cmd = 3'd1; ps = 2'd3; pw = ~zero; end
      S_JUMP: begin
        pw = 1'b1;
        ps = (op == 6'h00) ? 2'd2 : 2'd1;
        if (op == 6'h03) begin rw = 1'b1; wa = 2'd2; di = 2'd2; end
      end
      S_TRAP:   begin tr = 1'b1; eb = be; end
      default:  tr = 1'b0;
    endcase
    return {mReq, mWe, ioD, ir, pw, ps, aA, aB, cmd, rw, wa, di, tr, eb};
  endfunction

  function automatic void push(logic [3:0] st, logic [5:0] op, logic [5:0] fn,
                               logic rdy, logic zero, logic be, string tag);
    sbEntry e;
    e.st   = st;
    e.op   = op;
    e.fn   = fn;
    e.rdy  = rdy;
    e.zero = zero;
    e.ctl  = specCtl(st, op, fn, rdy, zero, be);
    e.tag  = tag;
    sbQ.push_back(e);
  endfunction

  // Pulse reset from mid-cycle, release at a falling edge, and let the first
  // rising edge after release arm the fetch.
  task automatic doReset();
    rstN = 1'b0;
    bus.memReady = 1'b0;
    aluZero = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
  endtask

  task automatic test_reset();
    rstN = 1'b1;
    opcode = 6'h00;
    funct = 6'h20;
    aluZero = 1'b0;
    bus.memReady = 1'b0;
    #2 rstN = 1'b0;
    #2 bus.memReady = 1'b1;
    #1;
    checks++;
    if (dbgState !== S_FETCH || obsCtl !== 20'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: state=%0d ctl=%h, expected state=0 ctl=00000", dbgState, obsCtl);
    end
    @(negedge clk);
    bus.memReady = 1'b0;
    rstN = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (dbgState !== S_FETCH || bus.memReq !== 1'b1) begin
      errors++;
      $display("[TB] FAIL first_fetch: state=%0d memReq=%b, expected state=0 memReq=1", dbgState, bus.memReq);
    end
    #2 rstN = 1'b0;
    #1;
    checks++;
    if (dbgState !== S_FETCH || bus.memReq !== 1'b0 || obsCtl !== 20'h0) begin
      errors++;
      $display("[TB] FAIL reset_mid_fetch: state=%0d memReq=%b ctl=%h, expected state=0 memReq=0 ctl=00000",
               dbgState, bus.memReq, obsCtl);
    end
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
  endtask

  task automatic test_add();
    sbEntry e;
    push(S_FETCH,  6'h00, 6'h20, 1'b1, 1'b0, 1'b0, "add_fetch");
    push(S_DECODE, 6'h00, 6'h20, 1'b1, 1'b0, 1'b0, "add_decode");
    push(S_EXECR,  6'h00, 6'h20, 1'b1, 1'b0, 1'b0, "add_exec");
    push(S_WBALU,  6'h00, 6'h20, 1'b1, 1'b0, 1'b0, "add_wb");
    while (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      @(negedge clk);
      opcode = e.op; funct = e.fn; bus.memReady = e.rdy; aluZero = e.zero;
      #1;
      checks++;
      if (dbgState !== e.st || obsCtl !== e.ctl) begin
        errors++;
        $display("[TB] FAIL %s: state=%0d ctl=%h, expected state=%0d ctl=%h", e.tag, dbgState, obsCtl, e.st, e.ctl);
      end
    end
  endtask

  task automatic test_alu_ops();
    sbEntry e;
    logic [5:0] ops[4] = '{6'h00, 6'h00, 6'h08, 6'h0E};
    logic [5:0] fns[4] = '{6'h22, 6'h2A, 6'h00, 6'h00};
    for (int i = 0; i < 4; i++) begin
      push(S_FETCH,  ops[i], fns[i], 1'b1, 1'b0, 1'b0, $sformatf("alu%0d_fetch", i));
      push(S_DECODE, ops[i], fns[i], 1'b1, 1'b0, 1'b0, $sformatf("alu%0d_decode", i));
      push((ops[i] == 6'h00) ? S_EXECR : S_EXECI, ops[i], fns[i], 1'b1, 1'b0, 1'b0, $sformatf("alu%0d_exec", i));
      push(S_WBALU,  ops[i], fns[i], 1'b1, 1'b0, 1'b0, $sformatf("alu%0d_wb", i));
    end
    while (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      @(negedge clk);
      opcode = e.op; funct = e.fn; bus.memReady = e.rdy; aluZero = e.zero;
      #1;
      checks++;
      if (dbgState !== e.st || obsCtl !== e.ctl) begin
        errors++;
        $display("[TB] FAIL %s: state=%0d ctl=%h, expected state=%0d ctl=%h", e.tag, dbgState, obsCtl, e.st, e.ctl);
      end
    end
  endtask

  task automatic test_lw_wait();
    sbEntry e;
    push(S_FETCH,  6'h23, 6'h00, 1'b1, 1'b0, 1'b0, "lw_fetch");
    push(S_DECODE, 6'h23, 6'h00, 1'b1, 1'b0, 1'b0, "lw_decode");
    push(S_MADDR,  6'h23, 6'h00, 1'b1, 1'b0, 1'b0, "lw_addr");
    for (int i = 0; i < 3; i++) push(S_MRD, 6'h23, 6'h00, 1'b0, 1'b0, 1'b0, "lw_rd_wait");
    push(S_MRD,    6'h23, 6'h00, 1'b1, 1'b0, 1'b0, "lw_rd_ack");
    push(S_WBMEM,  6'h23, 6'h00, 1'b1, 1'b0, 1'b0, "lw_wb");
    while (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      @(negedge clk);
      opcode = e.op; funct = e.fn; bus.memReady = e.rdy; aluZero = e.zero;
      #1;
      checks++;
      if (dbgState !== e.st || obsCtl !== e.ctl) begin
        errors++;
        $display("[TB] FAIL %s: state=%0d ctl=%h, expected state=%0d ctl=%h", e.tag, dbgState, obsCtl, e.st, e.ctl);
      end
    end
  endtask

  task automatic test_sw();
    sbEntry e;
    push(S_FETCH,  6'h2B, 6'h00, 1'b1, 1'b0, 1'b0, "sw_fetch");
    push(S_DECODE, 6'h2B, 6'h00, 1'b1, 1'b0, 1'b0, "sw_decode");
    push(S_MADDR,  6'h2B, 6'h00, 1'b1, 1'b0, 1'b0, "sw_addr");
    push(S_MWR,    6'h2B, 6'h00, 1'b0, 1'b0, 1'b0, "sw_wr_wait");
    push(S_MWR,    6'h2B, 6'h00, 1'b1, 1'b0, 1'b0, "sw_wr_ack");
    while (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      @(negedge clk);
      opcode = e.op; funct = e.fn; bus.memReady = e.rdy; aluZero = e.zero;
      #1;
      checks++;
      if (dbgState !== e.st || obsCtl !== e.ctl) begin
        errors++;
        $display("[TB] FAIL %s: state=%0d ctl=%h, expected state=%0d ctl=%h", e.tag, dbgState, obsCtl, e.st, e.ctl);
      end
    end
  endtask

  task automatic test_bne();
    sbEntry e;
    push(S_FETCH,  6'h05, 6'h00, 1'b1, 1'b1, 1'b0, "bne_fetch");
    push(S_DECODE, 6'h05, 6'h00, 1'b1, 1'b0, 1'b0, "bne_decode");
    push(S_BRANCH, 6'h05, 6'h00, 1'b1, 1'b0, 1'b0, "bne_taken");
    push(S_FETCH,  6'h05, 6'h00, 1'b1, 1'b0, 1'b0, "bne2_fetch");
    push(S_DECODE, 6'h05, 6'h00, 1'b1, 1'b1, 1'b0, "bne2_decode");
    push(S_BRANCH, 6'h05, 6'h00, 1'b1, 1'b1, 1'b0, "bne_not_taken");
    while (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      @(negedge clk);
      opcode = e.op; funct = e.fn; bus.memReady = e.rdy; aluZero = e.zero;
      #1;
      checks++;
      if (dbgState !== e.st || obsCtl !== e.ctl) begin
        errors++;
        $display("[TB] FAIL %s: state=%0d ctl=%h, expected state=%0d ctl=%h", e.tag, dbgState, obsCtl, e.st, e.ctl);
      end
    end
  endtask

  task automatic test_jump();
    sbEntry e;
    logic [5:0] ops[3] = '{6'h03, 6'h02, 6'h00};
    logic [5:0] fns[3] = '{6'h00, 6'h00, 6'h08};
    for (int i = 0; i < 3; i++) begin
      push(S_FETCH,  ops[i], fns[i], 1'b1, 1'b0, 1'b0, $sformatf("jmp%0d_fetch", i));
      push(S_DECODE, ops[i], fns[i], 1'b1, 1'b0, 1'b0, $sformatf("jmp%0d_decode", i));
      push(S_JUMP,   ops[i], fns[i], 1'b1, 1'b0, 1'b0, $sformatf("jmp%0d_jump", i));
    end
    while (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      @(negedge clk);
      opcode = e.op; funct = e.fn; bus.memReady = e.rdy; aluZero = e.zero;
      #1;
      checks++;
      if (dbgState !== e.st || obsCtl !== e.ctl) begin
        errors++;
        $display("[TB] FAIL %s: state=%0d ctl=%h, expected state=%0d ctl=%h", e.tag, dbgState, obsCtl, e.st, e.ctl);
      end
    end
  endtask

  task automatic test_back_to_back();
    sbEntry e;
    push(S_FETCH,  6'h08, 6'h00, 1'b0, 1'b0, 1'b0, "b2b_fetch_wait0");
    push(S_FETCH,  6'h08, 6'h00, 1'b0, 1'b0, 1'b0, "b2b_fetch_wait1");
    push(S_FETCH,  6'h08, 6'h00, 1'b1, 1'b0, 1'b0, "b2b_fetch_ack");
    push(S_DECODE, 6'h08, 6'h00, 1'b0, 1'b0, 1'b0, "b2b_addi_decode");
    push(S_EXECI,  6'h08, 6'h00, 1'b1, 1'b0, 1'b0, "b2b_addi_exec");
    push(S_WBALU,  6'h08, 6'h00, 1'b1, 1'b0, 1'b0, "b2b_addi_wb");
    push(S_FETCH,  6'h23, 6'h00, 1'b1, 1'b0, 1'b0, "b2b_lw_fetch");
    push(S_DECODE, 6'h23, 6'h00, 1'b1, 1'b0, 1'b0, "b2b_lw_decode");
    push(S_MADDR,  6'h23, 6'h00, 1'b1, 1'b0, 1'b0, "b2b_lw_addr");
    push(S_MRD,    6'h23, 6'h00, 1'b1, 1'b0, 1'b0, "b2b_lw_rd");
    push(S_WBMEM,  6'h23, 6'h00, 1'b1, 1'b0, 1'b0, "b2b_lw_wb");
    while (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      @(negedge clk);
      opcode = e.op; funct = e.fn; bus.memReady = e.rdy; aluZero = e.zero;
      #1;
      checks++;
      if (dbgState !== e.st || obsCtl !== e.ctl) begin
        errors++;
        $display("[TB] FAIL %s: state=%0d ctl=%h, expected state=%0d ctl=%h", e.tag, dbgState, obsCtl, e.st, e.ctl);
      end
    end
  endtask

  task automatic test_illegal();
    sbEntry e;
    push(S_FETCH,  6'h3F, 6'h00, 1'b1, 1'b0, 1'b0, "ill_fetch");
    push(S_DECODE, 6'h3F, 6'h00, 1'b1, 1'b0, 1'b0, "ill_decode");
    for (int i = 0; i < 20; i++) push(S_TRAP, 6'h3F, 6'h00, 1'b1, 1'b0, 1'b0, "ill_trap_hold");
    while (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      @(negedge clk);
      opcode = e.op; funct = e.fn; bus.memReady = e.rdy; aluZero = e.zero;
      #1;
      checks++;
      if (dbgState !== e.st || obsCtl !== e.ctl) begin
        errors++;
        $display("[TB] FAIL %s: state=%0d ctl=%h, expected state=%0d ctl=%h", e.tag, dbgState, obsCtl, e.st, e.ctl);
      end
    end
    #1 rstN = 1'b0;
    #1;
    checks++;
    if (dbgState !== S_FETCH || trap !== 1'b0 || busErr !== 1'b0) begin
      errors++;
      $display("[TB] FAIL trap_async_reset: state=%0d trap=%b busErr=%b, expected state=0 trap=0 busErr=0",
               dbgState, trap, busErr);
    end
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
  endtask

  task automatic test_timeout();
    sbEntry e;
    for (int i = 0; i < 16; i++) push(S_FETCH, 6'h00, 6'h20, 1'b0, 1'b0, 1'b0, "to_fetch_wait");
    for (int i = 0; i < 3; i++)  push(S_TRAP,  6'h00, 6'h20, 1'b1, 1'b0, 1'b1, "to_trap");
    while (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      @(negedge clk);
      opcode = e.op; funct = e.fn; bus.memReady = e.rdy; aluZero = e.zero;
      #1;
      checks++;
      if (dbgState !== e.st || obsCtl !== e.ctl) begin
        errors++;
        $display("[TB] FAIL %s: state=%0d ctl=%h, expected state=%0d ctl=%h", e.tag, dbgState, obsCtl, e.st, e.ctl);
      end
    end
    doReset();
    for (int i = 0; i < 15; i++) push(S_FETCH, 6'h00, 6'h20, 1'b0, 1'b0, 1'b0, "late_fetch_wait");
    push(S_FETCH,  6'h00, 6'h20, 1'b1, 1'b0, 1'b0, "late_fetch_ack");
    push(S_DECODE, 6'h00, 6'h20, 1'b1, 1'b0, 1'b0, "late_decode");
    push(S_EXECR,  6'h00, 6'h20, 1'b1, 1'b0, 1'b0, "late_exec");
    push(S_WBALU,  6'h00, 6'h20, 1'b1, 1'b0, 1'b0, "late_wb");
    while (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      @(negedge clk);
      opcode = e.op; funct = e.fn; bus.memReady = e.rdy; aluZero = e.zero;
      #1;
      checks++;
      if (dbgState !== e.st || obsCtl !== e.ctl) begin
        errors++;
        $display("[TB] FAIL %s: state=%0d ctl=%h, expected state=%0d ctl=%h", e.tag, dbgState, obsCtl, e.st, e.ctl);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_alu_ops();
    test_lw_wait();
    test_sw();
    test_bne();
    test_jump();
    test_back_to_back();
    test_illegal();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at time %0t, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
